// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and decode constants for the iterative multiply/divide unit
package muldiv_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/response bundle between the pipeline and the multiply/divide unit
interface muldiv_if #(parameter int XLEN = 32);

    logic            start;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            is_md;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, opcode, funct3, funct7, rs1_data, rs2_data, flush,
        input  is_md, stall, busy, done, result
    );

    modport slave (
        input  start, opcode, funct3, funct7, rs1_data, rs2_data, flush,
        output is_md, stall, busy, done, result
    );

endinterface

// File: rtl/muldiv_decode.sv
// muldiv_decode: combinational M-extension decode into op, operand signedness and result half
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic       is_md_o,
    output md_op_e     op_o,
    output logic       a_signed_o,
    output logic       b_signed_o,
    output logic       is_div_o,
    output logic       want_high_o
);

    // for divides the "high" half of the accumulator is the remainder
    always_comb begin
        is_md_o     = (opcode_i == OPC_RTYPE) && (funct7_i == F7_MULDIV);
        op_o        = md_op_e'(funct3_i);
        a_signed_o  = funct3_i[2] ? !funct3_i[0] : (funct3_i != 3'b011);
        b_signed_o  = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
        is_div_o    = funct3_i[2];
        want_high_o = funct3_i[2] ? funct3_i[1] : (funct3_i != 3'b000);
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, stalls the pipeline while busy
// Shift-add multiply and restoring divide share one 2*XLEN accumulator; signs are fixed up at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    logic            is_md, a_signed, b_signed, is_div, want_high;
    md_op_e          op;

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] b_q, b_d;
    md_op_e          op_q, op_d;
    logic            neg_q, neg_d, aneg_q, aneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_neg, b_neg, accept, div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;
    logic            is_div_q, high_q;
    logic [XLEN:0]   mul_sum, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, iter, prod;
    logic [XLEN-1:0] half, mul_res, div_res, calc_res;

    muldiv_decode u_decode (
        .opcode_i    (bus.opcode),
        .funct3_i    (bus.funct3),
        .funct7_i    (bus.funct7),
        .is_md_o     (is_md),
        .op_o        (op),
        .a_signed_o  (a_signed),
        .b_signed_o  (b_signed),
        .is_div_o    (is_div),
        .want_high_o (want_high)
    );

    always_comb begin
        a_neg    = a_signed && bus.rs1_data[XLEN-1];
        b_neg    = b_signed && bus.rs2_data[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
        accept   = (state_q == ST_IDLE) && bus.start && is_md && !bus.flush;
        div_zero = is_div && (bus.rs2_data == '0);
        ovf      = is_div && a_signed && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.rs2_data == {XLEN{1'b1}});
        spec_res = div_zero ? (want_high ? bus.rs1_data : {XLEN{1'b1}})
                            : (want_high ? {XLEN{1'b0}} : bus.rs1_data);
    end

    // one iteration of each algorithm; low half holds multiplier bits / dividend bits still to consume
    always_comb begin
        is_div_q = op_q[2];
        high_q   = op_q[2] ? op_q[1] : (op_q != OP_MUL);
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? b_q : {XLEN{1'b0}}};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        iter     = is_div_q ? div_next : mul_next;
        prod     = neg_q ? -iter : iter;
        mul_res  = high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        half     = high_q ? iter[2*XLEN-1:XLEN] : iter[XLEN-1:0];
        div_res  = (high_q ? aneg_q : neg_q) ? -half : half;
        calc_res = is_div_q ? div_res : mul_res;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        aneg_d   = aneg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d   = op;
                neg_d  = a_neg ^ b_neg;
                aneg_d = a_neg;
                acc_d  = {{XLEN{1'b0}}, a_mag};
                b_d    = b_mag;
                if (div_zero || ovf) begin
                    state_d  = ST_DONE;
                    result_d = spec_res;
                end else begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(XLEN);
                end
            end
            ST_CALC: begin
                acc_d = iter;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = calc_res;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            aneg_q   <= aneg_d;
            result_q <= result_d;
        end
    end

    assign bus.is_md  = is_md;
    assign bus.stall  = accept || (state_q == ST_CALC);
    assign bus.busy   = state_q != ST_IDLE;
    assign bus.done   = state_q == ST_DONE;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 1;
    endfunction

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.opcode   = OPC_RTYPE;
        bus.funct7   = F7_MULDIV;
        bus.funct3   = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
    endtask

    // drives one op from a negedge and reports when done rose and what it carried
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int dcyc, output logic [31:0] res, output int nstall, output int nbusy);
        @(negedge clk);
        present(f3, a, b);
        #1;
        nstall = int'(bus.stall);
        nbusy  = 0;
        dcyc   = -1;
        res    = 'x;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            nstall += int'(bus.stall);
            nbusy  += int'(bus.busy);
            if (bus.done) begin
                dcyc = c;
                res  = bus.result;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks += 4;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6};
        logic [31:0] as  [10] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd1234, 32'h8000_0000};
        logic [31:0] bs  [10] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] exp [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd0};
        int dcyc, ns, nb, lat;
        logic [31:0] res;
        for (int i = 0; i < 10; i++) begin
            run_op(f3s[i], as[i], bs[i], dcyc, res, ns, nb);
            lat = (i >= 8) ? 1 : XLEN + 1;
            n_checks += 4;
            if (res !== exp[i]) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, res, exp[i]); end
            if (dcyc !== lat) begin n_fail++; $display("FAIL dir%0d_done_cycle got %0d want %0d", i, dcyc, lat); end
            if (ns !== lat) begin n_fail++; $display("FAIL dir%0d_stall_cycles got %0d want %0d", i, ns, lat); end
            if (nb !== lat) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, nb, lat); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        int dcyc, ns, nb;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(f3, a, b, dcyc, res, ns, nb);
            n_checks += 2;
            if (res !== model(f3, a, b)) begin
                n_fail++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, res, model(f3, a, b));
            end
            if (dcyc !== latency(f3, a, b)) begin
                n_fail++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", i, dcyc, latency(f3, a, b));
            end
        end
    endtask

    task automatic test_flush();
        int dcyc, ns, nb, first_done;
        logic [31:0] res;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, res, ns, nb);
        @(negedge clk);
        present(3'd0, 32'd12345, 32'd678);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        present(3'd0, 32'hDEAD_BEEF, 32'h0000_1003);
        #1;
        n_checks += 4;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", bus.done); end
        if (bus.result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL flush_result_held got %h want fffffffe", bus.result); end
        if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL flush_restart_stall got %b want 1", bus.stall); end
        first_done = -1;
        for (int c = 12; c <= 80 && first_done < 0; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.done) begin first_done = c; res = bus.result; end
        end
        n_checks += 2;
        if (first_done !== 44) begin n_fail++; $display("FAIL flush_restart_done_cycle got %0d want 44", first_done); end
        if (res !== model(3'd0, 32'hDEAD_BEEF, 32'h0000_1003)) begin
            n_fail++; $display("FAIL flush_restart_result got %h want %h", res, model(3'd0, 32'hDEAD_BEEF, 32'h0000_1003));
        end
    endtask

    task automatic test_back_to_back();
        int dcyc, ns, nb, first_done;
        logic [31:0] res;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, dcyc, res, ns, nb);
        present(3'd5, 32'd100, 32'd7);
        #1;
        n_checks += 1;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cycle_stall got %b want 0", bus.stall); end
        @(negedge clk);
        #1;
        n_checks += 3;
        if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall got %b want 1", bus.stall); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_busy got %b want 0", bus.busy); end
        if (bus.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL b2b_result_held got %h want ffffffeb", bus.result); end
        first_done = -1;
        for (int c = 1; c <= 60 && first_done < 0; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.done) begin first_done = c; res = bus.result; end
        end
        n_checks += 2;
        if (first_done !== XLEN + 1) begin n_fail++; $display("FAIL b2b_done_cycle got %0d want %0d", first_done, XLEN + 1); end
        if (res !== 32'd14) begin n_fail++; $display("FAIL b2b_result got %h want 0000000e", res); end
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        present(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b want 0", bus.done); end
        if (bus.result !== 32'd0) begin n_fail++; $display("FAIL areset_result got %h want 0", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            seen += int'(bus.busy) + int'(bus.done);
        end
        n_checks += 1;
        if (seen !== 0) begin n_fail++; $display("FAIL areset_no_replay got %0d active cycles want 0", seen); end
    endtask

    task automatic test_non_md();
        @(negedge clk);
        present(3'd0, 32'd5, 32'd6);
        bus.funct7 = 7'b0000000;
        #1;
        n_checks += 2;
        if (bus.is_md !== 1'b0) begin n_fail++; $display("FAIL add_is_md got %b want 0", bus.is_md); end
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL add_stall got %b want 0", bus.stall); end
        bus.funct7 = F7_MULDIV;
        bus.opcode = 7'b0010011;
        #1;
        n_checks += 1;
        if (bus.is_md !== 1'b0) begin n_fail++; $display("FAIL opimm_is_md got %b want 0", bus.is_md); end
        @(negedge clk);
        bus.start = 1'b0;
        bus.opcode = OPC_RTYPE;
        #1;
        n_checks += 3;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL add_busy got %b want 0", bus.busy); end
        if (bus.is_md !== 1'b1) begin n_fail++; $display("FAIL mul_is_md got %b want 1", bus.is_md); end
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL idle_nostart_stall got %b want 0", bus.stall); end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.opcode   = '0;
        bus.funct3   = '0;
        bus.funct7   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.flush    = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_non_md();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M-style multiply/divide execution unit, parametrised in datapath width. It sits in the EX stage beside the single-cycle ALU. It decodes `opcode`/`funct3`/`funct7` for the M-extension encodings. Accepted operations are computed over multiple cycles, and the unit stalls the pipeline until the result is ready.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two, ≥ 8.
- `CNT_W`, `$clog2(XLEN+1)`: iteration counter width (derived; do not override).

Clock and reset are fixed as one clock with an asynchronous, active-low reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: EX stage holds a valid instruction this cycle.
- `opcode` in 7: instruction opcode.
- `funct3` in 3: instruction funct3.
- `funct7` in 7: instruction funct7.
- `rs1_data` in `XLEN`: operand A.
- `rs2_data` in `XLEN`: operand B.
- `flush` in 1: synchronous abort (branch mispredict / trap).
- `is_md` out 1: combinational; instruction is an M-extension op.
- `stall` out 1: combinational; hold IF/ID/EX.
- `busy` out 1: registered; FSM not IDLE.
- `done` out 1: registered; one-cycle result-valid pulse.
- `result` out `XLEN`: registered result; holds until next `done`.

## Operation
- Decode: `is_md = (opcode==7'b0110011) && (funct7==7'b0000001)`.
- `funct3` selects the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states are IDLE, CALC, DONE.
  - IDLE→CALC on `start && is_md && !flush`.
  - IDLE→DONE directly for special divide cases.
  - CALC→DONE when the counter reaches 0.
  - DONE→IDLE unconditionally.
  - `flush` forces any state→IDLE.
- Accept (IDLE only):
  - Latch the operand magnitudes, the sign flags, the op, and `cnt = XLEN`.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
- Multiply: unsigned shift-add of magnitudes into a 2·`XLEN` product, one bit per CALC cycle.
  - Negate (two's complement, 2·`XLEN` wide) if the operand signs differ.
  - MUL returns the low `XLEN` bits; MULH/MULHSU/MULHU return the high `XLEN` bits.
- Divide: restoring division of magnitudes, one quotient bit per CALC cycle.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Special cases (skip CALC):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return `rs1_data`.
  - Signed overflow (`rs1 = 1<<(XLEN-1)`, `rs2 = -1`): DIV returns `rs1`; REM returns 0.
- `start` while not IDLE is ignored. `start` with `!is_md` is ignored.
- `stall = (state==IDLE && start && is_md && !flush) || state==CALC`. `stall` is 0 in DONE so the pipeline advances and captures `result`.
- `flush` in the same cycle as `start` wins: no accept, `stall=0`.

## Timing
- Reset (async assert): state IDLE, `busy=0`, `done=0`, `result=0`, counter 0, datapath registers 0.
- Cycle 0 is the start cycle.
  - Normal ops: CALC occupies cycles 1..`XLEN`; `done=1` in cycle `XLEN+1` (33 at `XLEN=32`).
  - Special cases: `done=1` in cycle 1.
- `result` updates on the same edge that raises `done`, and is held afterwards.
- `busy` is 1 from cycle 1 through the DONE cycle inclusive.
- `flush` in CALC: `busy=0` and no `done` from the next cycle; `result` unchanged. A new `start` is accepted the cycle after the flush.
- Reset deasserted mid-operation: the unit restarts in IDLE; the lost op is not replayed.
- Back-to-back: a `start` in the DONE cycle is ignored; the pipeline re-presents the next op in the following cycle.

## Structure
- `muldiv_pkg` holds:
  - `md_op_e` (8 ops, encoded by `funct3`);
  - `md_state_e` (IDLE/CALC/DONE);
  - `OPC_RTYPE = 7'b0110011`;
  - `F7_MULDIV = 7'b0000001`.
- One sub-module, `muldiv_decode`: combinational; outputs `is_md`, `md_op_e`, `a_signed`, `b_signed`, `is_div`, `want_high`.
- Top level holds the FSM, counter, a shared 2·`XLEN` accumulator/remainder register, and sign fixup.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3) → `result=0xFFFFFFEB`, `done` in cycle 33, `stall` high in cycles 0..32.
- MULH 0x80000000×0x80000000 → `0x40000000`; MULHU 0xFFFFFFFF×0xFFFFFFFF → `0xFFFFFFFE`; MULHSU 0xFFFFFFFF×2 → `0xFFFFFFFF`.
- DIV −7/2 → `0xFFFFFFFD`; REM −7/2 → `0xFFFFFFFF`; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU x/0 → `0xFFFFFFFF`; REM 0x80000000 / 0xFFFFFFFF → 0. Both give `done` in cycle 1 with no CALC.
- `flush` in CALC cycle 10 → no `done` pulse, `busy=0` in cycle 11, `result` unchanged; a new MUL accepted in cycle 11 completes in cycle 44.
- `rst_n` low asynchronously mid-CALC → `busy`/`done`/`result` go to 0 immediately. ADD opcode with `start=1` → `is_md=0`, `stall=0`, state stays IDLE.
